// File: rtl/jtag_pkg.sv
// ============================================================================
// jtag_pkg: TAP state encoding, opcodes, strobe bundle and next-state function
// Rev 1.0
// ============================================================================
`default_nettype none

package jtag_pkg;

    typedef enum logic [3:0] {
        EXIT2_DR         = 4'h0,
        EXIT1_DR         = 4'h1,
        SHIFT_DR         = 4'h2,
        PAUSE_DR         = 4'h3,
        SELECT_IR        = 4'h4,
        UPDATE_DR        = 4'h5,
        CAPTURE_DR       = 4'h6,
        SELECT_DR        = 4'h7,
        EXIT2_IR         = 4'h8,
        EXIT1_IR         = 4'h9,
        SHIFT_IR         = 4'hA,
        PAUSE_IR         = 4'hB,
        RUN_TEST_IDLE    = 4'hC,
        UPDATE_IR        = 4'hD,
        CAPTURE_IR       = 4'hE,
        TEST_LOGIC_RESET = 4'hF
    } tap_state_e;

    localparam logic [4:0] IR_IDCODE = 5'h01;
    localparam logic [4:0] IR_BYPASS = 5'h1F;

    typedef enum logic [1:0] {
        DR_BYPASS = 2'd0,
        DR_IDCODE = 2'd1,
        DR_USER   = 2'd2
    } dr_sel_e;

    // One-clk action strobes; tdo_* mark a falling TCK edge inside a shift state.
    typedef struct packed {
        logic capture_ir;
        logic shift_ir;
        logic update_ir;
        logic capture_dr;
        logic shift_dr;
        logic update_dr;
        logic tdo_ir;
        logic tdo_dr;
    } tap_strb_t;

    function automatic tap_state_e tap_next(input tap_state_e state, input logic tms);
        tap_state_e nxt;
        case (state)
            TEST_LOGIC_RESET: nxt = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    nxt = tms ? SELECT_DR        : RUN_TEST_IDLE;
            SELECT_DR:        nxt = tms ? SELECT_IR        : CAPTURE_DR;
            CAPTURE_DR:       nxt = tms ? EXIT1_DR         : SHIFT_DR;
            SHIFT_DR:         nxt = tms ? EXIT1_DR         : SHIFT_DR;
            EXIT1_DR:         nxt = tms ? UPDATE_DR        : PAUSE_DR;
            PAUSE_DR:         nxt = tms ? EXIT2_DR         : PAUSE_DR;
            EXIT2_DR:         nxt = tms ? UPDATE_DR        : SHIFT_DR;
            UPDATE_DR:        nxt = tms ? SELECT_DR        : RUN_TEST_IDLE;
            SELECT_IR:        nxt = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       nxt = tms ? EXIT1_IR         : SHIFT_IR;
            SHIFT_IR:         nxt = tms ? EXIT1_IR         : SHIFT_IR;
            EXIT1_IR:         nxt = tms ? UPDATE_IR        : PAUSE_IR;
            PAUSE_IR:         nxt = tms ? EXIT2_IR         : PAUSE_IR;
            EXIT2_IR:         nxt = tms ? UPDATE_IR        : SHIFT_IR;
            UPDATE_IR:        nxt = tms ? SELECT_DR        : RUN_TEST_IDLE;
            default:          nxt = TEST_LOGIC_RESET;
        endcase
        return nxt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/jtag_tap_fsm.sv
// ============================================================================
// jtag_tap_fsm: TCK edge detect, 16-state TAP register and one-clk strobes
// Rev 1.0
// ============================================================================
`default_nettype none

module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       tck_i,
    input  logic       tms_i,
    input  logic       tdi_i,
    input  logic       trst_ni,
    output tap_state_e state_o,
    output tap_strb_t  strb_o,
    output logic       tdi_o
);

    logic       tck_q;
    logic       tdi_q;
    logic       tck_rise;
    logic       tck_fall;
    tap_state_e state_q;
    tap_strb_t  strb_q;

    assign tck_rise = tck_i & ~tck_q;
    assign tck_fall = ~tck_i & tck_q;

    // Rising-edge actions belong to the state being left; falling-edge ones to the current state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tck_q   <= 1'b0;
            tdi_q   <= 1'b0;
            state_q <= TEST_LOGIC_RESET;
            strb_q  <= '0;
        end else begin
            tck_q  <= tck_i;
            strb_q <= '0;
            if (!trst_ni) begin
                state_q <= TEST_LOGIC_RESET;
            end else if (tck_rise) begin
                state_q           <= tap_next(state_q, tms_i);
                tdi_q             <= tdi_i;
                strb_q.capture_ir <= (state_q == CAPTURE_IR);
                strb_q.shift_ir   <= (state_q == SHIFT_IR);
                strb_q.capture_dr <= (state_q == CAPTURE_DR);
                strb_q.shift_dr   <= (state_q == SHIFT_DR);
            end else if (tck_fall) begin
                strb_q.update_ir  <= (state_q == UPDATE_IR);
                strb_q.update_dr  <= (state_q == UPDATE_DR);
                strb_q.tdo_ir     <= (state_q == SHIFT_IR);
                strb_q.tdo_dr     <= (state_q == SHIFT_DR);
            end
        end
    end

    // A TAP reset arriving while a strobe is registered suppresses that strobe.
    assign strb_o  = trst_ni ? strb_q : '0;
    assign state_o = state_q;
    assign tdi_o   = tdi_q;

endmodule

`default_nettype wire

// File: rtl/jtag_tap_sampled.sv
// ============================================================================
// jtag_tap_sampled: oversampled TAP with IR, IDCODE/BYPASS DRs and USER DR port
// Rev 1.0
// ============================================================================
`default_nettype none

module jtag_tap_sampled
    import jtag_pkg::*;
#(
    parameter int unsigned           IR_LEN  = 5,
    parameter logic [31:0]           IDCODE  = 32'h249511C3,
    parameter logic [IR_LEN-1:0]     USER_IR = IR_LEN'(5'h10)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              jtag_tck_i,
    input  logic              jtag_tms_i,
    input  logic              jtag_trst_ni,
    input  logic              jtag_tdi_i,
    output logic              jtag_tdo_o,
    output logic [3:0]        tap_state_o,
    output logic [IR_LEN-1:0] ir_o,
    output logic              user_sel_o,
    output logic              capture_dr_o,
    output logic              shift_dr_o,
    output logic              update_dr_o,
    output logic              user_tdi_o,
    input  logic              user_tdo_i
);

    localparam logic [IR_LEN-1:0] OP_IDCODE = IR_LEN'(IR_IDCODE);

    tap_state_e        state;
    tap_strb_t         strb;
    logic              tdi_s;
    logic [IR_LEN-1:0] ir_q;
    logic [IR_LEN-1:0] ir_sr_q;
    logic [31:0]       dr_sr_q;
    logic              byp_q;
    logic              tdo_q;
    logic              tdo_d;
    dr_sel_e           dr_sel;

    jtag_tap_fsm u_fsm (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .tck_i   (jtag_tck_i),
        .tms_i   (jtag_tms_i),
        .tdi_i   (jtag_tdi_i),
        .trst_ni (jtag_trst_ni),
        .state_o (state),
        .strb_o  (strb),
        .tdi_o   (tdi_s)
    );

    // Anything that is neither IDCODE nor USER falls back to BYPASS.
    always_comb begin
        dr_sel = DR_BYPASS;
        if (ir_q == OP_IDCODE) begin
            dr_sel = DR_IDCODE;
        end else if (ir_q == USER_IR) begin
            dr_sel = DR_USER;
        end
    end

    always_comb begin
        tdo_d = tdo_q;
        if (strb.tdo_ir) begin
            tdo_d = ir_sr_q[0];
        end else if (strb.tdo_dr) begin
            case (dr_sel)
                DR_IDCODE: tdo_d = dr_sr_q[0];
                DR_USER:   tdo_d = user_tdo_i;
                default:   tdo_d = byp_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ir_q    <= OP_IDCODE;
            ir_sr_q <= '0;
            dr_sr_q <= '0;
            byp_q   <= 1'b0;
            tdo_q   <= 1'b0;
        end else begin
            tdo_q <= tdo_d;

            if (!jtag_trst_ni || state == TEST_LOGIC_RESET) begin
                ir_q <= OP_IDCODE;
            end else if (strb.update_ir) begin
                ir_q <= ir_sr_q;
            end

            if (strb.capture_ir) begin
                ir_sr_q <= IR_LEN'(2'b01);
            end else if (strb.shift_ir) begin
                ir_sr_q <= {tdi_s, ir_sr_q[IR_LEN-1:1]};
            end

            if (strb.capture_dr) begin
                if (dr_sel == DR_IDCODE) begin
                    dr_sr_q <= IDCODE;
                end else if (dr_sel == DR_BYPASS) begin
                    byp_q <= 1'b0;
                end
            end else if (strb.shift_dr) begin
                if (dr_sel == DR_IDCODE) begin
                    dr_sr_q <= {tdi_s, dr_sr_q[31:1]};
                end else if (dr_sel == DR_BYPASS) begin
                    byp_q <= tdi_s;
                end
            end
        end
    end

    assign jtag_tdo_o   = tdo_q;
    assign tap_state_o  = state;
    assign ir_o         = ir_q;
    assign user_sel_o   = (dr_sel == DR_USER);
    assign capture_dr_o = strb.capture_dr & user_sel_o;
    assign shift_dr_o   = strb.shift_dr & user_sel_o;
    assign update_dr_o  = strb.update_dr & user_sel_o;
    assign user_tdi_o   = tdi_s;

endmodule

`default_nettype wire
